regfile_param: RTL and testbench



---
 rtl/regfile_param.sv | 127 ++++++++++++
 tb/tb_regfile_param.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised 1W/2R register file: registered reads with write-through bypass, and a
// one-entry-per-cycle clear sweep after reset. Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_param #(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 4,
    parameter int                 DEPTH     = 16,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    input  logic              WR,
    input  logic              RD,
    input  logic [DATA_W-1:0] Ip1,
    input  logic [ADDR_W-1:0] sel_i1,
    input  logic [ADDR_W-1:0] sel_o1,
    input  logic [ADDR_W-1:0] sel_o2,
    output logic [DATA_W-1:0] Op1,
    output logic [DATA_W-1:0] Op2,
    output logic              busy
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [0:0]        ST_CLEAR = 1'b0;
    localparam logic [0:0]        ST_READY = 1'b1;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state_reg;
    logic [ADDR_W-1:0] clr_ptr_reg;
    logic              busy_reg;

    logic              wr_ok;
    logic              wr_en_next;
    logic [IDX_W-1:0]  wr_idx_next;
    logic [DATA_W-1:0] wr_data_next;

    // An address is backed by storage if it is in range and not the hardwired zero entry.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_A) && !(ZERO_REG && (a == '0));
    endfunction

    assign wr_ok = EN && WR && addr_ok(sel_i1);

    // Sweep and functional writes share the single write port.
    always_comb begin
        wr_en_next   = 1'b0;
        wr_idx_next  = sel_i1[IDX_W-1:0];
        wr_data_next = Ip1;
        if (!rst) begin
            if (state_reg == ST_CLEAR) begin
                wr_en_next   = 1'b1;
                wr_idx_next  = clr_ptr_reg[IDX_W-1:0];
                wr_data_next = RESET_VAL;
            end else begin
                wr_en_next   = wr_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_next) begin
            mem[wr_idx_next] <= wr_data_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
            busy_reg    <= 1'b1;
        end else if (state_reg == ST_CLEAR) begin
            if (clr_ptr_reg == LAST_IDX) begin
                state_reg <= ST_READY;
                busy_reg  <= 1'b0;
            end else begin
                clr_ptr_reg <= clr_ptr_reg + 1'b1;
            end
        end
    end

    logic [ADDR_W-1:0] rd_sel [2];
    assign rd_sel[0] = sel_o1;
    assign rd_sel[1] = sel_o2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic              bypass;
            logic [DATA_W-1:0] rd_data_next;
            logic [DATA_W-1:0] q_reg;

            // wr_ok already excludes dropped writes, so the bypass never forwards them.
            assign bypass = wr_ok && (sel_i1 == rd_sel[gi]);

            always_comb begin
                rd_data_next = '0;
                if (bypass) begin
                    rd_data_next = Ip1;
                end else if (addr_ok(rd_sel[gi])) begin
                    rd_data_next = mem[rd_sel[gi][IDX_W-1:0]];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg <= '0;
                end else if ((state_reg == ST_READY) && EN && RD) begin
                    q_reg <= rd_data_next;
                end
            end
        end
    endgenerate

    assign Op1  = g_rd[0].q_reg;
    assign Op2  = g_rd[1].q_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a behavioural model is checked every cycle,
// plus hand-computed literal expectations at each stage.
module tb_regfile_param;

    localparam int          DW    = 32;
    localparam int          AW    = 5;
    localparam int          DEPTH = 16;
    localparam logic [31:0] RV    = 32'h5A5A_0F0F;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          EN = 1'b0, WR = 1'b0, RD = 1'b0;
    logic [DW-1:0] Ip1 = '0;
    logic [AW-1:0] sel_i1 = '0, sel_o1 = '0, sel_o2 = '0;
    logic [DW-1:0] Op1, Op2;
    logic          busy;

    int errors = 0;
    int checks = 0;

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .EN(EN), .WR(WR), .RD(RD), .Ip1(Ip1),
        .sel_i1(sel_i1), .sel_o1(sel_o1), .sel_o2(sel_o2),
        .Op1(Op1), .Op2(Op2), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: storage array plus a count of entries still to clear.
    logic [31:0] mm [DEPTH];
    int          left    = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_op1 = '0, m_op2 = '0;

    function automatic logic [31:0] m_read(input int a, input bit w_ok, input int wa, input logic [31:0] wd);
        if (a >= DEPTH || (ZR && a == 0)) return 32'h0;
        if (w_ok && a == wa) return wd;
        return mm[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            left    = DEPTH;
            m_op1   = '0;
            m_op2   = '0;
            m_valid = 1'b1;
        end else if (left > 0) begin
            mm[DEPTH - left] = RV;
            left = left - 1;
        end else if (EN) begin
            bit w_ok;
            w_ok = WR && (int'(sel_i1) < DEPTH) && !(ZR && sel_i1 == 0);
            if (RD) begin
                m_op1 = m_read(int'(sel_o1), w_ok, int'(sel_i1), Ip1);
                m_op2 = m_read(int'(sel_o2), w_ok, int'(sel_i1), Ip1);
            end
            if (w_ok) mm[int'(sel_i1)] = Ip1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_op1", Op1, m_op1);
            chk("model_op2", Op2, m_op2);
            chk("model_busy", {31'b0, busy}, {31'b0, left > 0});
        end
    end

    task automatic step(input logic r, input logic e, input logic w, input logic rd,
                        input logic [31:0] d, input int wi, input int o1, input int o2);
        rst = r; EN = e; WR = w; RD = rd; Ip1 = d;
        sel_i1 = AW'(wi); sel_o1 = AW'(o1); sel_o2 = AW'(o2);
        @(negedge clk);
        $display("txn t=%0t rst=%b en=%b wr=%b rd=%b ip1=%h wa=%0d ra=%0d/%0d -> op1=%h op2=%h busy=%b",
                 $time, r, e, w, rd, d, wi, o1, o2, Op1, Op2, busy);
    endtask

    // Steps until busy drops, optionally hammering a write/read at entry 1 meanwhile.
    task automatic sweep_count(input bit noisy, output int n);
        n = 0;
        do begin
            step(1'b0, noisy, noisy, noisy, 32'h9999_9999, 1, 1, 1);
            n++;
        end while (busy && n < 40);
    endtask

    int n;

    initial begin
        @(negedge clk);
        // 1. reset sweep
        step(1'b1, 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_op1", Op1, 32'h0);
        sweep_count(1'b0, n);
        chk("sweep_edges", n, 32'd16);
        step(0, 1, 0, 1, 0, 0, 5, 15);
        chk("clr_op1", Op1, RV);
        chk("clr_op2", Op2, RV);

        // 2. write/read
        step(0, 1, 1, 0, 32'hABCD_EFAB, 0, 0, 0);
        step(0, 1, 1, 0, 32'h0123_4567, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 1);
        chk("wr_op1", Op1, ZR ? 32'h0 : 32'hABCD_EFAB);
        chk("wr_op2", Op2, 32'h0123_4567);

        // 3. bypass
        step(0, 1, 1, 0, 32'h1111_1111, 3, 0, 0);
        step(0, 1, 1, 0, 32'h4444_4444, 4, 0, 0);
        step(0, 1, 1, 1, 32'h2222_2222, 3, 3, 4);
        chk("byp_op1", Op1, 32'h2222_2222);
        chk("byp_op2", Op2, 32'h4444_4444);
        step(0, 1, 0, 1, 0, 0, 3, 3);
        chk("byp_later", Op1, 32'h2222_2222);
        chk("same_addr", Op2, 32'h2222_2222);

        // out-of-range write dropped (no alias onto entry 4), read returns 0
        step(0, 1, 1, 0, 32'h7777_7777, 20, 0, 0);
        step(0, 1, 1, 1, 32'h8888_8888, 20, 20, 4);
        chk("oor_rd", Op1, 32'h0);
        chk("oor_alias", Op2, 32'h4444_4444);

        // 4. hold / enable
        step(0, 0, 1, 0, 32'hDEAD_BEEF, 2, 0, 0);
        step(0, 1, 0, 1, 0, 0, 2, 4);
        chk("en_off_wr", Op1, RV);
        step(0, 1, 0, 0, 0, 0, 7, 1);
        chk("hold_op1", Op1, RV);
        chk("hold_op2", Op2, 32'h4444_4444);
        step(0, 0, 0, 1, 0, 0, 7, 1);
        chk("en_off_rd", Op2, 32'h4444_4444);

        // 5. mid-sweep reset; writes while busy are lost
        step(1'b1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        step(1'b1, 0, 0, 0, 0, 0, 0, 0);
        sweep_count(1'b1, n);
        chk("resweep_edges", n, 32'd16);
        step(0, 1, 0, 1, 0, 0, 1, 3);
        chk("busy_wr_lost", Op1, RV);
        chk("resweep_clr", Op2, RV);

        // 6. entry 0 behaviour
        step(0, 1, 1, 1, 32'hFFFF_FFFF, 0, 0, 1);
        chk("zero_byp", Op1, ZR ? 32'h0 : 32'hFFFF_FFFF);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        chk("zero_later", Op1, ZR ? 32'h0 : 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
